// File: rtl/afifo_rd_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : afifo_rd_ctrl_if
// Purpose  : Bus bundle between the async-FIFO read controller and its
//            environment (pointer exchange, RAM read port, output stream).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface afifo_rd_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH:0]   wr_ptr_gray_i;
    logic [ADDR_WIDTH:0]   rd_ptr_gray_o;
    logic                  mem_rd_en_o;
    logic [ADDR_WIDTH-1:0] mem_rd_addr_o;
    logic [DATA_WIDTH-1:0] mem_rd_data_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i;
    logic [ADDR_WIDTH:0]   count_o;
    logic                  empty_o;
    logic                  err_o;

    modport slave (
        input  wr_ptr_gray_i, mem_rd_data_i, ready_i,
        output rd_ptr_gray_o, mem_rd_en_o, mem_rd_addr_o,
               data_o, valid_o, count_o, empty_o, err_o
    );

    modport master (
        output wr_ptr_gray_i, mem_rd_data_i, ready_i,
        input  rd_ptr_gray_o, mem_rd_en_o, mem_rd_addr_o,
               data_o, valid_o, count_o, empty_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/afifo_rd_ctrl.sv
//------------------------------------------------------------------------------
// Module   : afifo_rd_ctrl
// Purpose  : Read-domain controller of a dual-clock FIFO: write-pointer sync,
//            occupancy/error status and RAM-to-output-register sequencing.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module afifo_rd_ctrl #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire                 clk_i,
    input  wire                 rst_ni,
    afifo_rd_ctrl_if.slave      bus
);

    localparam int             PW    = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]  DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           sync_q [SYNC_STAGES];
    logic [PW-1:0]           sync_d [SYNC_STAGES];
    logic [PW-1:0]           rd_bin_q, rd_bin_d;
    logic [PW-1:0]           rd_gray_q, rd_gray_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic [PW-1:0]           wr_gray_s;
    logic [PW-1:0]           wr_bin_s;
    logic [PW-1:0]           count;
    logic                    avail;
    logic                    issue;

    // Only the Gray-coded pointer is sampled across the clock boundary.
    always_comb begin
        sync_d[0] = bus.wr_ptr_gray_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        wr_gray_s = sync_q[SYNC_STAGES-1];
        for (int i = 0; i < PW; i++) begin
            wr_bin_s[i] = ^(wr_gray_s >> i);
        end
    end

    always_comb begin
        count = wr_bin_s - rd_bin_q;
        avail = (count != '0);
        err_d = err_q | (count > DEPTH);
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        issue     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (avail) begin
                    issue   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                data_d  = bus.mem_rd_data_i;
                valid_d = 1'b1;
                state_d = ST_FULL;
            end
            ST_FULL: begin
                if (bus.ready_i) begin
                    valid_d = 1'b0;
                    if (avail) begin
                        issue   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_EMPTY;
            end
        endcase

        rd_bin_d  = rd_bin_q;
        rd_gray_d = rd_gray_q;
        // The slot is released at issue; the RAM word is captured next cycle,
        // long before the writer can observe the advanced pointer.
        if (issue) begin
            rd_bin_d  = rd_bin_q + 1'b1;
            rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            state_q   <= ST_EMPTY;
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            state_q   <= state_d;
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= rd_gray_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign bus.rd_ptr_gray_o = rd_gray_q;
    assign bus.mem_rd_en_o   = issue;
    assign bus.mem_rd_addr_o = rd_bin_q[ADDR_WIDTH-1:0];
    assign bus.data_o        = data_q;
    assign bus.valid_o       = valid_q;
    assign bus.count_o       = count;
    assign bus.empty_o       = !avail;
    assign bus.err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_afifo_rd_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_afifo_rd_ctrl
// Purpose  : Self-checking bench for afifo_rd_ctrl with a 1-cycle RAM model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_afifo_rd_ctrl;

    logic clk;
    logic rst_n;

    afifo_rd_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

    afifo_rd_ctrl #(
        .ADDR_WIDTH  (4),
        .DATA_WIDTH  (8),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [16];

    always @(posedge clk) begin
        if (bus.mem_rd_en_o) bus.mem_rd_data_i <= ram[bus.mem_rd_addr_o];
    end

    typedef struct {
        int wr_bin;
        int exp_count;
        int exp_empty;
        int exp_valid;
        int exp_err;
    } vec_t;

    vec_t vecs [6];

    int tests;
    int fails;

    logic [7:0] q_data [$];
    logic [3:0] q_addr [$];
    logic [4:0] q_gray [$];

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [4:0] wr);
        @(negedge clk);
        rst_n            = 1'b0;
        bus.wr_ptr_gray_i = wr;
        bus.ready_i       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge; accepts n words with ready held high.
    task automatic drain(input int n);
        logic [4:0] prev;
        int cyc;
        q_data.delete();
        q_addr.delete();
        q_gray.delete();
        prev        = bus.rd_ptr_gray_o;
        bus.ready_i = 1'b1;
        cyc         = 0;
        while (q_data.size() < n && cyc < n * 3 + 10) begin
            if (bus.mem_rd_en_o) q_addr.push_back(bus.mem_rd_addr_o);
            if (bus.valid_o) q_data.push_back(bus.data_o);
            if (bus.rd_ptr_gray_o != prev) begin
                q_gray.push_back(bus.rd_ptr_gray_o);
                prev = bus.rd_ptr_gray_o;
            end
            @(negedge clk);
            cyc++;
        end
        check("drain_words", q_data.size(), n);
        bus.ready_i = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int cyc;
        cyc = 0;
        while (!bus.valid_o && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check(name, bus.valid_o, 1);
    endtask

    initial begin
        int ok;
        tests = 0;
        fails = 0;
        for (int i = 0; i < 16; i++) ram[i] = 8'((i * 37 + 11) & 8'hff);
        bus.mem_rd_data_i = '0;
        bus.ready_i       = 1'b0;
        bus.wr_ptr_gray_i = '0;
        rst_n             = 1'b0;

        // Reset values with a nonzero pointer already presented.
        bus.wr_ptr_gray_i = 5'b00011;
        repeat (3) @(negedge clk);
        check("rst_count", bus.count_o, 0);
        check("rst_empty", bus.empty_o, 1);
        check("rst_valid", bus.valid_o, 0);
        check("rst_data",  bus.data_o, 0);
        check("rst_err",   bus.err_o, 0);
        check("rst_rdgray", bus.rd_ptr_gray_o, 0);
        check("rst_rden",  bus.mem_rd_en_o, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_count", bus.count_o, 2);
        wait_valid("rel_valid");
        check("rel_data", bus.data_o, ram[0]);

        // Table: occupancy, empty, valid and sticky error with ready low.
        vecs[0] = '{0,  0,  1, 0, 0};
        vecs[1] = '{1,  0,  1, 1, 0};
        vecs[2] = '{5,  4,  0, 1, 0};
        vecs[3] = '{17, 16, 0, 1, 0};
        vecs[4] = '{18, 17, 0, 1, 1};
        vecs[5] = '{17, 16, 0, 1, 1};
        do_reset(5'b00000);
        for (int v = 0; v < 6; v++) begin
            bus.wr_ptr_gray_i = gray(vecs[v].wr_bin);
            repeat (5) @(negedge clk);
            check($sformatf("vec%0d_count", v), bus.count_o, vecs[v].exp_count);
            check($sformatf("vec%0d_empty", v), bus.empty_o, vecs[v].exp_empty);
            check($sformatf("vec%0d_valid", v), bus.valid_o, vecs[v].exp_valid);
            check($sformatf("vec%0d_err",   v), bus.err_o,   vecs[v].exp_err);
            if (vecs[v].exp_valid != 0)
                check($sformatf("vec%0d_data", v), bus.data_o, ram[0]);
        end
        drain(17);
        check("ovf_err_after_drain", bus.err_o, 1);
        check("ovf_empty_after_drain", bus.empty_o, 1);

        // Full FIFO then drain in address order.
        do_reset(5'b00000);
        check("full_err_cleared", bus.err_o, 0);
        bus.wr_ptr_gray_i = gray(16);
        repeat (2) @(negedge clk);
        check("full_count", bus.count_o, 16);
        check("full_err", bus.err_o, 0);
        check("full_issue", bus.mem_rd_en_o, 1);
        drain(16);
        for (int i = 0; i < 16 && i < q_data.size(); i++)
            check($sformatf("full_data%0d", i), q_data[i], ram[i]);
        for (int i = 0; i < 16 && i < q_addr.size(); i++)
            check($sformatf("full_addr%0d", i), q_addr[i], i);
        check("full_gray_steps", q_gray.size(), 16);
        ok = 1;
        for (int i = 0; i < q_gray.size(); i++) begin
            if (q_gray[i] != gray(i + 1)) ok = 0;
            if (i > 0 && $countones(q_gray[i] ^ q_gray[i-1]) != 1) ok = 0;
        end
        check("full_gray_seq", ok, 1);
        @(negedge clk);
        check("full_end_empty", bus.empty_o, 1);
        check("full_end_valid", bus.valid_o, 0);

        // Backpressure: three words queued, consumer stalls.
        bus.wr_ptr_gray_i = gray(19);
        wait_valid("bp_valid");
        check("bp_count", bus.count_o, 2);
        check("bp_data", bus.data_o, ram[0]);
        ok = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!bus.valid_o || bus.data_o != ram[0] || bus.mem_rd_en_o) ok = 0;
        end
        check("bp_frozen", ok, 1);
        check("bp_count_held", bus.count_o, 2);
        drain(3);
        for (int i = 0; i < 3 && i < q_data.size(); i++)
            check($sformatf("bp_data%0d", i), q_data[i], ram[i]);

        // Wrap: bring the read pointer to 30, then write pointer wraps to 2.
        bus.wr_ptr_gray_i = gray(30);
        repeat (2) @(negedge clk);
        drain(11);
        @(negedge clk);
        check("wrap_pre_empty", bus.empty_o, 1);
        bus.wr_ptr_gray_i = gray(2);
        repeat (2) @(negedge clk);
        check("wrap_count", bus.count_o, 4);
        drain(4);
        for (int i = 0; i < 4 && i < q_addr.size(); i++)
            check($sformatf("wrap_addr%0d", i), q_addr[i], (14 + i) % 16);
        for (int i = 0; i < 4 && i < q_data.size(); i++)
            check($sformatf("wrap_data%0d", i), q_data[i], ram[(14 + i) % 16]);
        check("wrap_gray_steps", q_gray.size(), 4);
        if (q_gray.size() >= 2) begin
            check("wrap_gray31", q_gray[0], gray(31));
            check("wrap_gray0",  q_gray[1], 0);
        end

        // Asynchronous reset while the output register holds a word.
        @(negedge clk);
        bus.wr_ptr_gray_i = gray(3);
        wait_valid("arst_full_valid");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_full_valid0", bus.valid_o, 0);
        check("arst_full_data0",  bus.data_o, 0);
        check("arst_full_count0", bus.count_o, 0);
        bus.wr_ptr_gray_i = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset during FETCH.
        bus.wr_ptr_gray_i = gray(1);
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk);
            if (bus.mem_rd_en_o) ok = 1;
        end
        check("arst_fetch_issue", ok, 1);
        @(posedge clk);
        #2;
        check("arst_fetch_gray_pre", bus.rd_ptr_gray_o, gray(1));
        rst_n = 1'b0;
        #1;
        check("arst_fetch_gray0", bus.rd_ptr_gray_o, 0);
        check("arst_fetch_valid0", bus.valid_o, 0);
        bus.wr_ptr_gray_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.valid_o || bus.mem_rd_en_o) ok = 0;
        end
        check("arst_no_spurious", ok, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
